uart_tx_scheduler: RTL

Round-robin scheduler that shares the single UART transmitter among NREQ byte requesters. It accepts one byte at a time from the selected requester and drives the transmitter's tx_en/tx_data. It then waits for tx_done and reports per-requester completion. A watchdog aborts a hung frame through tx_rst. It sits between the client blocks and the UART transmitter, alongside the APB slave, on the PCLK domain.

---
 rtl/uart_sched_pkg.sv | 9 +
 rtl/uart_tx_scheduler_rr_pick.sv | 21 ++
 rtl/uart_tx_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding, defaults and index-width helper for the UART TX scheduler
package uart_sched_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT, ABORT} state_e;
    localparam int DEF_TIMEOUT = 150000;
    localparam int DEF_TO_W    = 18;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector, double-width masked priority encode starting at ptr
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int GW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   grant,
    output logic            any
);
    logic [2*NREQ-1:0] dbl;
    always_comb begin
        dbl   = {req, req};
        grant = '0;
        any   = |req;
        for (int j = 2*NREQ-1; j >= 0; j--)
            if (dbl[j] && j >= int'(ptr)) grant = GW'(j % NREQ);
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter among NREQ byte requesters with watchdog abort
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TO_W    = DEF_TO_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int GW = idx_w(NREQ)
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    req_done,
    output logic [NREQ-1:0]    req_err,
    output logic               tx_en,
    output logic [DW-1:0]      tx_data,
    output logic               tx_rst,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [GW-1:0]      grant_id,
    output logic               active
);
    state_e            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d, grant_q, grant_d, pick, ptr_nxt;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]     tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d, tx_rst_q, tx_rst_d, active_q, active_d, any;
    logic [NREQ-1:0]   req_ready_q, req_ready_d, req_done_q, req_done_d, req_err_q, req_err_d;
    logic              timeout;

    rr_pick #(.NREQ(NREQ)) u_pick (.req(req_valid), .ptr(ptr_q), .grant(pick), .any(any));

    assign ptr_nxt = (int'(grant_q) == NREQ-1) ? '0 : grant_q + 1'b1;
    assign timeout = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = tx_en_q;
        tx_rst_d    = 1'b0;
        req_ready_d = '0;
        req_done_d  = '0;
        req_err_d   = '0;
        case (state_q)
            IDLE: if (any && !tx_busy) begin
                state_d     = SEND;
                grant_d     = pick;
                tx_data_d   = req_data[int'(pick)*DW +: DW];
                tx_en_d     = 1'b1;
                cnt_d       = '0;
                req_ready_d = NREQ'(1) << pick;
            end
            SEND, WAIT: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // completion takes priority over a coincident watchdog expiry
                if (tx_done) begin
                    state_d    = IDLE;
                    tx_en_d    = 1'b0;
                    req_done_d = NREQ'(1) << grant_q;
                    ptr_d      = ptr_nxt;
                end else if (timeout) begin
                    state_d   = ABORT;
                    tx_en_d   = 1'b0;
                    tx_rst_d  = 1'b1;
                    req_err_d = NREQ'(1) << grant_q;
                    ptr_d     = ptr_nxt;
                end else if (state_q == SEND && tx_busy) begin
                    state_d = WAIT;
                    tx_en_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            tx_data_q   <= '0;
            tx_en_q     <= 1'b0;
            tx_rst_q    <= 1'b0;
            active_q    <= 1'b0;
            req_ready_q <= '0;
            req_done_q  <= '0;
            req_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            tx_rst_q    <= tx_rst_d;
            active_q    <= active_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_done  = req_done_q;
    assign req_err   = req_err_q;
    assign tx_en     = tx_en_q;
    assign tx_data   = tx_data_q;
    assign tx_rst    = tx_rst_q;
    assign grant_id  = grant_q;
    assign active    = active_q;
endmodule
